// File: rtl/cavlc_block_sched_if.sv
// cavlc_block_sched_if: parser/core handshake bundle around the CAVLC block scheduler.
interface cavlc_block_sched_if;
  logic       FrameStart;
  logic       MbStart;
  logic       MbSkip;
  logic       MbReady;
  logic       MbDone;
  logic       FrameDone;
  logic       CavlcEnable;
  logic [4:0] nC;
  logic       BlockDone;
  logic [4:0] TotalCoeffOut;
  logic [3:0] BlkIdx;
  modport slave (
    input  FrameStart, MbStart, MbSkip, BlockDone, TotalCoeffOut,
    output MbReady, MbDone, FrameDone, CavlcEnable, nC, BlkIdx
  );
  modport master (
    output FrameStart, MbStart, MbSkip, BlockDone, TotalCoeffOut,
    input  MbReady, MbDone, FrameDone, CavlcEnable, nC, BlkIdx
  );
endinterface

// File: rtl/cavlc_block_sched.sv
// cavlc_block_sched: Z-scan block sequencer and nC context generator for the CAVLC core.
module cavlc_block_sched #(
  parameter int MB_WIDTH  = 120,
  parameter int MB_HEIGHT = 68
) (
  input logic               Clk,
  input logic               nReset,
  cavlc_block_sched_if.slave bus
);
  localparam int XW = MB_WIDTH > 1 ? $clog2(MB_WIDTH) : 1;
  localparam int YW = MB_HEIGHT > 1 ? $clog2(MB_HEIGHT) : 1;
  localparam int TW = XW + 2;
  typedef enum logic [2:0] {IDLE, CALC, RUN, STORE, SKIP, DONE} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_blk;
  logic [XW-1:0] r_mbx;
  logic [YW-1:0] r_mby;
  logic [4:0]    r_nc, r_tc;
  logic [4:0]    r_grid [16];
  logic [4:0]    r_left [4];
  logic [4:0]    r_top  [MB_WIDTH*4];
  logic [1:0]    w_bx, w_by, w_xa, w_yb;
  logic [3:0]    w_idx_a, w_idx_b;
  logic [TW-1:0] w_top_addr;
  logic [4:0]    w_na, w_nb, w_nc, w_wd;
  logic [5:0]    w_sum;
  logic          w_av_a, w_av_b, w_last_blk, w_last_x, w_last_y, w_we;
  assign w_bx       = {r_blk[2], r_blk[0]};
  assign w_by       = {r_blk[3], r_blk[1]};
  assign w_xa       = w_bx - 2'd1;
  assign w_yb       = w_by - 2'd1;
  assign w_idx_a    = {w_by[1], w_xa[1], w_by[0], w_xa[0]};
  assign w_idx_b    = {w_yb[1], w_bx[1], w_yb[0], w_bx[0]};
  assign w_top_addr = {r_mbx, w_bx};
  assign w_av_a     = (w_bx != 2'd0) || (r_mbx != '0);
  assign w_av_b     = (w_by != 2'd0) || (r_mby != '0);
  assign w_na       = w_bx != 2'd0 ? r_grid[w_idx_a] : r_left[w_by];
  assign w_nb       = w_by != 2'd0 ? r_grid[w_idx_b] : r_top[w_top_addr];
  // Six-bit sum keeps 16+16+1 from wrapping before the halving.
  assign w_sum      = {1'b0, w_na} + {1'b0, w_nb} + 6'd1;
  assign w_nc       = (w_av_a && w_av_b) ? w_sum[5:1] : w_av_a ? w_na : w_av_b ? w_nb : 5'd0;
  assign w_last_blk = r_blk == 4'd15;
  assign w_last_x   = r_mbx == XW'(MB_WIDTH - 1);
  assign w_last_y   = r_mby == YW'(MB_HEIGHT - 1);
  assign w_we       = (r_state == STORE) || (r_state == SKIP);
  assign w_wd       = r_state == STORE ? r_tc : 5'd0;
  assign bus.MbReady     = r_state == IDLE;
  assign bus.MbDone      = r_state == DONE;
  assign bus.FrameDone   = (r_state == DONE) && w_last_x && w_last_y;
  assign bus.CavlcEnable = r_state == RUN;
  assign bus.nC          = r_nc;
  assign bus.BlkIdx      = r_blk;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.MbStart) w_next = bus.MbSkip ? SKIP : CALC;
      CALC:    w_next = RUN;
      RUN:     if (bus.BlockDone) w_next = STORE;
      STORE:   w_next = w_last_blk ? DONE : CALC;
      SKIP:    if (w_last_blk) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.FrameStart) w_next = IDLE;
  end
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_next;
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      r_blk <= '0;
      r_mbx <= '0;
      r_mby <= '0;
      r_nc  <= '0;
      r_tc  <= '0;
    end else if (bus.FrameStart) begin
      r_blk <= '0;
      r_mbx <= '0;
      r_mby <= '0;
    end else begin
      if (r_state == IDLE && bus.MbStart) r_blk <= '0;
      if (w_we && !w_last_blk) r_blk <= r_blk + 4'd1;
      if (r_state == CALC) r_nc <= w_nc;
      if (r_state == RUN && bus.BlockDone) r_tc <= bus.TotalCoeffOut;
      if (r_state == DONE) begin
        r_mbx <= w_last_x ? '0 : r_mbx + 1'b1;
        if (w_last_x) r_mby <= w_last_y ? '0 : r_mby + 1'b1;
      end
    end
  // Neighbour buffers hold data only; availability masks stale entries.
  always_ff @(posedge Clk)
    if (w_we && !bus.FrameStart) begin
      r_grid[r_blk] <= w_wd;
      if (w_bx == 2'd3) r_left[w_by] <= w_wd;
      if (w_by == 2'd3) r_top[w_top_addr] <= w_wd;
    end
endmodule

// File: tb/tb_cavlc_block_sched.sv
// tb_cavlc_block_sched: random-TC macroblock sequences checked against a picture-coordinate nC model.
module tb_cavlc_block_sched;
  localparam int W = 5;
  localparam int H = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cavlc_block_sched_if bus();
  cavlc_block_sched #(.MB_WIDTH(W), .MB_HEIGHT(H)) dut (.Clk(clk), .nReset(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  int pic [H*4][W*4];
  int mx = 0;
  int my = 0;
  logic [4:0] tcs [16];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int bx_of(input int b);
    return ((b >> 2) & 1) * 2 + (b & 1);
  endfunction
  function automatic int by_of(input int b);
    return ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
  endfunction
  function automatic int ref_nc(input int b);
    int gx, gy, na, nb;
    gx = mx * 4 + bx_of(b);
    gy = my * 4 + by_of(b);
    na = gx > 0 ? pic[gy][gx-1] : 0;
    nb = gy > 0 ? pic[gy-1][gx] : 0;
    if (gx > 0 && gy > 0) return (na + nb + 1) / 2;
    return na + nb;
  endfunction
  task automatic fill_rand();
    for (int i = 0; i < 16; i++) tcs[i] = 5'($urandom_range(0, 16));
  endtask
  task automatic advance_model();
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my + 1) % H;
    end
  endtask
  task automatic run_mb(input bit skip, input int abort_blk);
    int lat;
    bit fd;
    chk("ready_before_start", bus.MbReady, 1);
    bus.MbStart = 1'b1;
    bus.MbSkip  = skip;
    @(negedge clk);
    bus.MbStart = 1'b0;
    bus.MbSkip  = 1'b0;
    if (skip) begin
      for (int i = 0; i < 16; i++) begin
        chk("skip_no_done", bus.MbDone, 0);
        chk("skip_no_enable", bus.CavlcEnable, 0);
        chk("skip_blkidx", bus.BlkIdx, i);
        @(negedge clk);
      end
      for (int b = 0; b < 16; b++) pic[my*4+by_of(b)][mx*4+bx_of(b)] = 0;
    end else begin
      for (int b = 0; b < 16; b++) begin
        chk("calc_enable_low", bus.CavlcEnable, 0);
        if ($urandom_range(0, 1) == 1) begin
          bus.BlockDone     = 1'b1;
          bus.TotalCoeffOut = 5'($urandom_range(0, 31));
          bus.MbStart       = 1'b1;
          bus.MbSkip        = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.BlockDone = 1'b0;
        bus.MbStart   = 1'b0;
        bus.MbSkip    = 1'b0;
        chk("run_enable", bus.CavlcEnable, 1);
        chk("run_blkidx", bus.BlkIdx, b);
        chk("run_nc", bus.nC, ref_nc(b));
        if (b == abort_blk) begin
          bus.FrameStart = 1'b1;
          @(negedge clk);
          bus.FrameStart = 1'b0;
          chk("abort_enable_low", bus.CavlcEnable, 0);
          chk("abort_ready", bus.MbReady, 1);
          chk("abort_no_done", bus.MbDone, 0);
          @(negedge clk);
          chk("abort_still_no_done", bus.MbDone, 0);
          mx = 0;
          my = 0;
          return;
        end
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          @(negedge clk);
          chk("wait_enable", bus.CavlcEnable, 1);
          chk("wait_nc_stable", bus.nC, ref_nc(b));
        end
        bus.BlockDone     = 1'b1;
        bus.TotalCoeffOut = tcs[b];
        @(negedge clk);
        bus.BlockDone     = 1'b0;
        bus.TotalCoeffOut = 5'($urandom_range(0, 31));
        pic[my*4+by_of(b)][mx*4+bx_of(b)] = tcs[b];
        chk("store_enable_low", bus.CavlcEnable, 0);
        @(negedge clk);
      end
    end
    fd = (mx == W - 1) && (my == H - 1);
    chk("mb_done", bus.MbDone, 1);
    chk("frame_done", bus.FrameDone, fd);
    advance_model();
    @(negedge clk);
    chk("ready_after_done", bus.MbReady, 1);
    chk("done_is_pulse", bus.MbDone, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask
  task automatic frame_start();
    bus.FrameStart = 1'b1;
    @(negedge clk);
    bus.FrameStart = 1'b0;
    mx = 0;
    my = 0;
  endtask
  initial begin
    bus.FrameStart    = 1'b0;
    bus.MbStart       = 1'b0;
    bus.MbSkip        = 1'b0;
    bus.BlockDone     = 1'b0;
    bus.TotalCoeffOut = 5'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.MbReady, 1);
    chk("rst_done", bus.MbDone, 0);
    chk("rst_frame_done", bus.FrameDone, 0);
    chk("rst_enable", bus.CavlcEnable, 0);
    chk("rst_nc", bus.nC, 0);
    chk("rst_blkidx", bus.BlkIdx, 0);
    frame_start();
    fill_rand();
    tcs[0] = 5'd4; tcs[1] = 5'd6; tcs[2] = 5'd3;
    tcs[5] = 5'd2; tcs[7] = 5'd7; tcs[13] = 5'd0; tcs[15] = 5'd16;
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, -1);
    run_mb(1'b1, -1);
    for (int i = 0; i < 16; i++) tcs[i] = 5'd16;
    run_mb(1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      run_mb(1'b0, -1);
    end
    fill_rand();
    tcs[5] = 5'd16;
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, 6);
    bus.FrameStart = 1'b1;
    bus.MbStart    = 1'b1;
    @(negedge clk);
    bus.FrameStart = 1'b0;
    bus.MbStart    = 1'b0;
    chk("fs_ms_dropped", bus.MbReady, 1);
    @(negedge clk);
    chk("fs_ms_still_idle", bus.MbReady, 1);
    chk("fs_ms_no_enable", bus.CavlcEnable, 0);
    mx = 0;
    my = 0;
    fill_rand();
    run_mb(1'b0, -1);
    fill_rand();
    run_mb(1'b0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
